trap_ctrl: RTL and testbench

- Trap sequencer at the commit stage of the RISC-V core.
- Takes the packed 15-bit exception vector and pending interrupts of the committing instruction and selects one trap by fixed priority.
- Drains the LSU, pulses cause/epc/tval to the CSR file, then flushes the pipeline and redirects fetch.
- Also sequences mret/sret returns.

---
 rtl/trap_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_trap_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// Commit-stage trap sequencer: picks one interrupt/exception/xret, waits for the
// LSU to drain, strobes the CSR file for one cycle, then flushes and redirects fetch.
module trap_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            commit_valid,
    output logic            commit_ready,
    input  logic [XLEN-1:0] commit_pc,
    input  logic [XLEN-1:0] commit_tval,
    input  logic [14:0]     commit_except,
    input  logic [5:0]      irq_pending,
    input  logic [5:0]      irq_enable,
    input  logic            mstatus_mie,
    input  logic            mstatus_sie,
    input  logic [1:0]      priv,
    input  logic [15:0]     medeleg,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] stvec,
    input  logic [XLEN-1:0] mepc,
    input  logic [XLEN-1:0] sepc,
    input  logic            lsu_idle,
    output logic            csr_trap_we,
    output logic            csr_xret_we,
    output logic            csr_to_s,
    output logic [XLEN-1:0] csr_cause,
    output logic [XLEN-1:0] csr_epc,
    output logic [XLEN-1:0] csr_tval,
    output logic            flush,
    output logic            redirect_valid,
    input  logic            redirect_ready,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DRAIN    = 2'd1,
        S_WRITE    = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    state_t          state_r, state_s;
    logic [5:0]      irq_act_s;
    logic            irq_take_s, uret_alone_s, exc_any_s, xret_any_s, accept_s;
    logic [3:0]      irq_code_s, exc_code_s;
    logic [XLEN-1:0] exc_tval_s, mbase_s, sbase_s;
    logic [XLEN-1:0] sel_cause_s, sel_tval_s, sel_target_s;
    logic            sel_to_s_s, sel_xret_s;
    logic [XLEN-1:0] cause_r, epc_r, tval_r, target_r;
    logic            to_s_r, xret_r;
    logic            unused_s;

    // S-level interrupts never trap here and S never takes vectored traps.
    assign unused_s = &{1'b0, mstatus_sie, stvec[1:0]};

    assign irq_act_s    = irq_pending & irq_enable;
    assign irq_take_s   = (|irq_act_s) && ((priv != 2'd3) || mstatus_mie);
    assign uret_alone_s = commit_except[2] & ~commit_except[4] & ~commit_except[3];
    assign exc_any_s    = (|commit_except[14:5]) | (|commit_except[1:0]) | uret_alone_s;
    assign xret_any_s   = commit_except[4] | commit_except[3];
    assign accept_s     = (state_r == S_IDLE) && commit_valid && (irq_take_s || exc_any_s || xret_any_s);
    assign mbase_s      = {mtvec[XLEN-1:2], 2'b00};
    assign sbase_s      = {stvec[XLEN-1:2], 2'b00};

    // Fixed-priority interrupt code: mei > msi > mti > sei > ssi > sti.
    always_comb begin
        irq_code_s = 4'd0;
        if (irq_act_s[5])      irq_code_s = 4'd11;
        else if (irq_act_s[4]) irq_code_s = 4'd3;
        else if (irq_act_s[3]) irq_code_s = 4'd7;
        else if (irq_act_s[2]) irq_code_s = 4'd9;
        else if (irq_act_s[1]) irq_code_s = 4'd1;
        else if (irq_act_s[0]) irq_code_s = 4'd5;
        else                   irq_code_s = 4'd0;
    end

    // Fixed-priority exception cause and tval.
    always_comb begin
        exc_code_s = 4'd0;
        exc_tval_s = commit_tval;
        if (commit_except[0])       begin exc_code_s = 4'd3;  exc_tval_s = commit_pc; end
        else if (commit_except[13]) exc_code_s = 4'd12;
        else if (commit_except[14]) exc_code_s = 4'd1;
        else if (commit_except[1])  exc_code_s = 4'd2;
        else if (commit_except[8])  exc_code_s = 4'd0;
        else if (commit_except[5])  begin exc_code_s = 4'd8 + {2'b00, priv}; exc_tval_s = '0; end
        else if (commit_except[6])  exc_code_s = 4'd6;
        else if (commit_except[7])  exc_code_s = 4'd4;
        else if (commit_except[9])  exc_code_s = 4'd15;
        else if (commit_except[11]) exc_code_s = 4'd13;
        else if (commit_except[10]) exc_code_s = 4'd7;
        else if (commit_except[12]) exc_code_s = 4'd5;
        else if (uret_alone_s)      begin exc_code_s = 4'd2;  exc_tval_s = '0; end
        else                        begin exc_code_s = 4'd0;  exc_tval_s = '0; end
    end

    // Interrupt beats exception, exception beats xret, mret beats sret.
    always_comb begin
        sel_cause_s  = '0;
        sel_tval_s   = '0;
        sel_target_s = '0;
        sel_to_s_s   = 1'b0;
        sel_xret_s   = 1'b0;
        if (irq_take_s) begin
            sel_cause_s[XLEN-1] = 1'b1;
            sel_cause_s[3:0]    = irq_code_s;
            if (mtvec[1:0] == 2'b01)
                sel_target_s = mbase_s + {{(XLEN-6){1'b0}}, irq_code_s, 2'b00};
            else
                sel_target_s = mbase_s;
        end else if (exc_any_s) begin
            sel_cause_s[3:0] = exc_code_s;
            sel_tval_s       = exc_tval_s;
            sel_to_s_s       = (priv != 2'd3) && medeleg[exc_code_s];
            sel_target_s     = sel_to_s_s ? sbase_s : mbase_s;
        end else if (commit_except[4]) begin
            sel_xret_s   = 1'b1;
            sel_target_s = mepc;
        end else if (commit_except[3]) begin
            sel_xret_s   = 1'b1;
            sel_to_s_s   = 1'b1;
            sel_target_s = sepc;
        end else begin
            sel_xret_s = 1'b0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:     if (accept_s) state_s = S_DRAIN; else state_s = S_IDLE;
            S_DRAIN:    if (lsu_idle) state_s = S_WRITE; else state_s = S_DRAIN;
            S_WRITE:    state_s = S_REDIRECT;
            S_REDIRECT: if (redirect_ready) state_s = S_IDLE; else state_s = S_REDIRECT;
            default:    state_s = S_IDLE;
        endcase
    end

    // State register and trap record captured at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_IDLE;
            cause_r  <= '0;
            epc_r    <= '0;
            tval_r   <= '0;
            target_r <= '0;
            to_s_r   <= 1'b0;
            xret_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                cause_r  <= sel_cause_s;
                epc_r    <= commit_pc;
                tval_r   <= sel_tval_s;
                target_r <= sel_target_s;
                to_s_r   <= sel_to_s_s;
                xret_r   <= sel_xret_s;
            end
        end
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_ready   <= 1'b1;
            busy           <= 1'b0;
            csr_trap_we    <= 1'b0;
            csr_xret_we    <= 1'b0;
            csr_to_s       <= 1'b0;
            csr_cause      <= '0;
            csr_epc        <= '0;
            csr_tval       <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            commit_ready   <= (state_s == S_IDLE);
            busy           <= (state_s != S_IDLE);
            csr_trap_we    <= (state_s == S_WRITE) && !xret_r;
            csr_xret_we    <= (state_s == S_WRITE) && xret_r;
            csr_to_s       <= (state_s == S_WRITE) && to_s_r;
            csr_cause      <= (state_s == S_WRITE) ? cause_r : '0;
            csr_epc        <= (state_s == S_WRITE) ? epc_r : '0;
            csr_tval       <= (state_s == S_WRITE) ? tval_r : '0;
            flush          <= (state_s == S_REDIRECT);
            redirect_valid <= (state_s == S_REDIRECT);
            redirect_pc    <= (state_s == S_REDIRECT) ? target_r : '0;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: the stimulus pushes expected CSR writes and redirect
// targets into a queue; a monitor pops and compares them when the DUT strobes.
module tb_trap_ctrl;

    typedef struct {
        logic        xret;
        logic        to_s;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [31:0] tval;
        logic [31:0] rpc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        commit_valid = 1'b0, commit_ready;
    logic [31:0] commit_pc = 32'h0, commit_tval = 32'h0;
    logic [14:0] commit_except = 15'h0;
    logic [5:0]  irq_pending = 6'h0, irq_enable = 6'h0;
    logic        mstatus_mie = 1'b0, mstatus_sie = 1'b0;
    logic [1:0]  priv = 2'd3;
    logic [15:0] medeleg = 16'h0;
    logic [31:0] mtvec = 32'h8000_0000, stvec = 32'h4000_0000;
    logic [31:0] mepc = 32'h0, sepc = 32'h0;
    logic        lsu_idle = 1'b1;
    logic        csr_trap_we, csr_xret_we, csr_to_s;
    logic [31:0] csr_cause, csr_epc, csr_tval;
    logic        flush, redirect_valid;
    logic        redirect_ready = 1'b0;
    logic [31:0] redirect_pc;
    logic        busy;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t q[$];

    trap_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_pc(commit_pc), .commit_tval(commit_tval), .commit_except(commit_except),
        .irq_pending(irq_pending), .irq_enable(irq_enable),
        .mstatus_mie(mstatus_mie), .mstatus_sie(mstatus_sie), .priv(priv),
        .medeleg(medeleg), .mtvec(mtvec), .stvec(stvec), .mepc(mepc), .sepc(sepc),
        .lsu_idle(lsu_idle),
        .csr_trap_we(csr_trap_we), .csr_xret_we(csr_xret_we), .csr_to_s(csr_to_s),
        .csr_cause(csr_cause), .csr_epc(csr_epc), .csr_tval(csr_tval),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic xr, input logic ts, input logic [31:0] c,
                                input logic [31:0] ep, input logic [31:0] tv, input logic [31:0] rp);
        exp_t e;
        e.xret = xr; e.to_s = ts; e.cause = c; e.epc = ep; e.tval = tv; e.rpc = rp;
        return e;
    endfunction

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // Monitor: compares CSR strobes and redirect handshakes with the queued expectations.
    logic        redir_pend = 1'b0;
    logic [31:0] redir_exp = 32'h0;
    always begin
        @(negedge clk);
        #3;
        if (rst_n && (csr_trap_we || csr_xret_we)) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL strobe_unexpected actual=strobe required=none");
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("strobe_kind", {30'd0, csr_trap_we, csr_xret_we}, e.xret ? 32'd1 : 32'd2);
                chk("csr_to_s", {31'd0, csr_to_s}, {31'd0, e.to_s});
                if (!e.xret) begin
                    chk("csr_cause", csr_cause, e.cause);
                    chk("csr_epc", csr_epc, e.epc);
                    chk("csr_tval", csr_tval, e.tval);
                end
                redir_exp  = e.rpc;
                redir_pend = 1'b1;
            end
        end
        if (rst_n && redirect_valid && redirect_ready) begin
            n_checks++;
            if (!redir_pend) begin
                n_fail++;
                $display("FAIL redirect_unexpected actual=%h required=none", redirect_pc);
            end else begin
                chk("redirect_pc_hs", redirect_pc, redir_exp);
            end
            redir_pend = 1'b0;
        end
    end

    task automatic run_trap(input logic [14:0] exc, input logic [5:0] pend, input logic [5:0] en,
                            input logic mie, input logic [1:0] pr, input logic [31:0] pc,
                            input logic [31:0] tv, input int lsu_wait, input int rdly, input exp_t e);
        step();
        commit_valid = 1'b1; commit_except = exc; irq_pending = pend; irq_enable = en;
        mstatus_mie = mie; priv = pr; commit_pc = pc; commit_tval = tv;
        lsu_idle = (lsu_wait == 0); redirect_ready = 1'b0;
        chk("ready_at_accept", {31'd0, commit_ready}, 32'd1);
        q.push_back(e);
        step();
        commit_valid = 1'b0; commit_except = 15'h7fff; commit_pc = 32'hffff_fff0; commit_tval = 32'hffff_ffff;
        irq_pending = 6'h3f; irq_enable = 6'h3f;
        chk("busy_drain", {31'd0, busy}, 32'd1);
        chk("ready_drain", {31'd0, commit_ready}, 32'd0);
        for (int i = 0; i < lsu_wait; i++) begin
            chk("no_strobe_drain", {30'd0, csr_trap_we, csr_xret_we}, 32'd0);
            if (i == lsu_wait - 1) lsu_idle = 1'b1;
            step();
        end
        if (lsu_wait == 0) step();
        chk("strobe_timing", {30'd0, csr_trap_we, csr_xret_we}, e.xret ? 32'd1 : 32'd2);
        step();
        chk("strobe_one_cycle", {30'd0, csr_trap_we, csr_xret_we}, 32'd0);
        for (int d = 0; d <= rdly; d++) begin
            chk("redirect_valid", {31'd0, redirect_valid}, 32'd1);
            chk("flush", {31'd0, flush}, 32'd1);
            chk("redirect_pc_held", redirect_pc, e.rpc);
            chk("ready_redirect", {31'd0, commit_ready}, 32'd0);
            if (d == rdly) redirect_ready = 1'b1;
            step();
        end
        redirect_ready = 1'b0;
        chk("ready_after", {31'd0, commit_ready}, 32'd1);
        chk("redirect_drop", {30'd0, redirect_valid, flush}, 32'd0);
        chk("busy_after", {31'd0, busy}, 32'd0);
        irq_pending = 6'h0; irq_enable = 6'h0; commit_except = 15'h0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_commit_ready", {31'd0, commit_ready}, 32'd1);
        chk("rst_outputs", {28'd0, busy, flush, redirect_valid, csr_trap_we}, 32'd0);
        chk("rst_cause", csr_cause, 32'd0);
        #2 rst_n = 1'b1;

        // Load page fault in M.
        run_trap(15'h0800, 6'h0, 6'h0, 1'b0, 2'd3, 32'h8000_0100, 32'h0000_1234, 0, 0,
                 mk(1'b0, 1'b0, 32'd13, 32'h8000_0100, 32'h0000_1234, 32'h8000_0000));
        // Breakpoint beats fetch page fault; tval is the pc.
        run_trap(15'h2001, 6'h0, 6'h0, 1'b0, 2'd3, 32'h8000_1000, 32'h0000_dead, 0, 0,
                 mk(1'b0, 1'b0, 32'd3, 32'h8000_1000, 32'h8000_1000, 32'h8000_0000));
        // ecall from U delegated to S; vectored stvec still lands on base.
        medeleg = 16'h0100; stvec = 32'h4000_0001;
        run_trap(15'h0020, 6'h0, 6'h0, 1'b0, 2'd0, 32'h0000_2000, 32'h0000_7777, 0, 0,
                 mk(1'b0, 1'b1, 32'd8, 32'h0000_2000, 32'h0, 32'h4000_0000));
        // Machine timer interrupt beats store misalign; vectored mtvec.
        mtvec = 32'h8000_0001;
        run_trap(15'h0040, 6'h08, 6'h08, 1'b1, 2'd3, 32'h8000_0300, 32'h0000_0abc, 0, 0,
                 mk(1'b0, 1'b0, 32'h8000_0007, 32'h8000_0300, 32'h0, 32'h8000_001c));
        // Same with interrupts globally masked in M: store misalign, base pc.
        run_trap(15'h0040, 6'h08, 6'h08, 1'b0, 2'd3, 32'h8000_0300, 32'h0000_0abc, 0, 0,
                 mk(1'b0, 1'b0, 32'd6, 32'h8000_0300, 32'h0000_0abc, 32'h8000_0000));
        // mei beats sti from S mode regardless of mstatus_mie.
        run_trap(15'h0000, 6'h21, 6'h21, 1'b0, 2'd1, 32'h0000_4000, 32'h0, 0, 0,
                 mk(1'b0, 1'b0, 32'h8000_000b, 32'h0000_4000, 32'h0, 32'h8000_002c));
        // LSU busy: stays in DRAIN several cycles.
        run_trap(15'h0080, 6'h0, 6'h0, 1'b0, 2'd3, 32'h8000_0400, 32'h0000_0401, 6, 0,
                 mk(1'b0, 1'b0, 32'd4, 32'h8000_0400, 32'h0000_0401, 32'h8000_0000));
        // mret with redirect back-pressure.
        mepc = 32'h8000_0200;
        run_trap(15'h0010, 6'h0, 6'h0, 1'b0, 2'd3, 32'h8000_0500, 32'h0, 0, 3,
                 mk(1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 32'h8000_0200));
        // sret from S.
        sepc = 32'h0000_3300;
        run_trap(15'h0008, 6'h0, 6'h0, 1'b0, 2'd1, 32'h0000_5000, 32'h0, 0, 1,
                 mk(1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0000_3300));
        // uret alone acts as illegal instruction with zero tval.
        run_trap(15'h0004, 6'h0, 6'h0, 1'b0, 2'd3, 32'h8000_0600, 32'h0000_1111, 0, 0,
                 mk(1'b0, 1'b0, 32'd2, 32'h8000_0600, 32'h0, 32'h8000_0000));
        // Load page fault from S delegated to S.
        medeleg = 16'h2000; stvec = 32'h4000_1000;
        run_trap(15'h0800, 6'h0, 6'h0, 1'b0, 2'd1, 32'h0000_6000, 32'h0000_6666, 0, 0,
                 mk(1'b0, 1'b1, 32'd13, 32'h0000_6000, 32'h0000_6666, 32'h4000_1000));

        // Clean commit with a masked interrupt retires normally.
        step();
        commit_valid = 1'b1; commit_except = 15'h0; irq_pending = 6'h08; irq_enable = 6'h08;
        mstatus_mie = 1'b0; priv = 2'd3;
        step();
        commit_valid = 1'b0;
        chk("retire_busy", {31'd0, busy}, 32'd0);
        chk("retire_ready", {31'd0, commit_ready}, 32'd1);
        irq_pending = 6'h0;

        // Reset while redirecting.
        step();
        commit_valid = 1'b1; commit_except = 15'h0002; commit_pc = 32'h8000_3000; commit_tval = 32'h55;
        priv = 2'd3; lsu_idle = 1'b1; redirect_ready = 1'b0;
        q.push_back(mk(1'b0, 1'b0, 32'd2, 32'h8000_3000, 32'h55, 32'h8000_0000));
        step();
        commit_valid = 1'b0; commit_except = 15'h0;
        step();
        step();
        chk("pre_reset_redirect", {31'd0, redirect_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("reset_redirect", {30'd0, redirect_valid, flush}, 32'd0);
        chk("reset_ready", {30'd0, commit_ready, busy}, 32'd2);
        chk("reset_pc", redirect_pc, 32'd0);
        step();
        rst_n = 1'b1;
        run_trap(15'h0200, 6'h0, 6'h0, 1'b0, 2'd3, 32'h8000_0700, 32'h0000_0777, 0, 0,
                 mk(1'b0, 1'b0, 32'd15, 32'h8000_0700, 32'h0000_0777, 32'h8000_0000));

        repeat (2) step();
        chk("queue_empty", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
